// File: rtl/cart_pkg.sv
// Shared constants and types for the cartridge bank controller.
package cart_pkg;

  // Controller flavours selectable through MBC_MODE.
  localparam int MBC_NONE = 0;
  localparam int MBC1     = 1;
  localparam int MBC5     = 5;

  // Register/memory regions, keyed by CPU address bits [15:13].
  localparam logic [2:0] RGN_RAM_EN   = 3'd0;  // 0000-1FFF
  localparam logic [2:0] RGN_ROM_BANK = 3'd1;  // 2000-3FFF
  localparam logic [2:0] RGN_HI_BANK  = 3'd2;  // 4000-5FFF
  localparam logic [2:0] RGN_MODE     = 3'd3;  // 6000-7FFF
  localparam logic [2:0] RGN_CART_RAM = 3'd5;  // A000-BFFF

  // Nibble that unlocks the external cart RAM.
  localparam logic [3:0] RAM_EN_KEY = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_RAM   = 2'd2
  } cart_state_e;

  // ROM occupies the whole lower half of the CPU map.
  function automatic logic is_rom_addr(input logic [15:0] addr);
    return ~addr[15];
  endfunction

endpackage

// File: rtl/flash_async_reader.sv
// Single-word reader for asynchronous parallel NOR flash: latches the word
// address, waits FLASH_WAIT cycles for the array to settle, then presents
// the selected byte together with a one-cycle done strobe.
module flash_async_reader #(
  parameter int          FLASH_WAIT = 7,
  parameter logic [23:0] FLASH_BASE = 24'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [23:0] word_addr_i,
  input  logic        byte_sel_i,
  input  logic [15:0] flash_d_i,
  output logic [23:0] flash_a_o,
  output logic [7:0]  data_o,
  output logic        done_o
);

  localparam int             CW      = $clog2(FLASH_WAIT + 1);
  localparam logic [CW-1:0]  WAIT_LD = CW'(FLASH_WAIT);

  logic [23:0]   addr_q;
  logic          sel_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  // Latch the request and count down the flash access time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= FLASH_BASE;
      sel_q  <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
    end else if (start_i) begin
      addr_q <= word_addr_i;
      sel_q  <= byte_sel_i;
      cnt_q  <= WAIT_LD;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == {CW{1'b0}}) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign flash_a_o = addr_q;
  assign done_o    = busy_q & (cnt_q == {CW{1'b0}});
  assign data_o    = sel_q ? flash_d_i[15:8] : flash_d_i[7:0];

endmodule

// File: rtl/cartridge_mbc.sv
// Cartridge model: MBC1/MBC5 bank registers, ROM reads from parallel NOR
// flash with wait states, external cart RAM in BRAM, READY handshake.
module cartridge_mbc
  import cart_pkg::*;
#(
  parameter int          MBC_MODE      = 0,
  parameter int          ROM_BANK_BITS = 9,
  parameter int          RAM_BANK_BITS = 4,
  parameter int          FLASH_WAIT    = 7,
  parameter logic [23:0] FLASH_BASE    = 24'h0
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET_L,
  input  logic [15:0]                I_CARTRIDGE_ADDR,
  inout  wire  [7:0]                 IO_CARTRIDGE_DATA,
  input  logic                       I_CARTRIDGE_WE_L,
  input  logic                       I_CARTRIDGE_RE_L,
  output logic                       O_CARTRIDGE_READY,
  input  logic [15:0]                flash_d,
  output logic [23:0]                flash_a,
  output logic                       flash_clk,
  output logic                       flash_adv_n,
  output logic                       flash_ce_n,
  output logic                       flash_oe_n,
  output logic                       flash_we_n,
  output logic [RAM_BANK_BITS+12:0]  O_RAM_ADDR,
  output logic                       O_RAM_WE,
  output logic [7:0]                 O_RAM_DIN,
  input  logic [7:0]                 I_RAM_DOUT
);

  localparam logic [8:0] ROM_MASK = 9'((32'd1 << ROM_BANK_BITS) - 32'd1);
  localparam logic [3:0] RAM_MASK = 4'((32'd1 << RAM_BANK_BITS) - 32'd1);
  localparam logic       IS_MBC1  = (MBC_MODE == MBC1);
  localparam logic       IS_MBC5  = (MBC_MODE == MBC5);
  localparam logic       BANKED   = (MBC_MODE != MBC_NONE);

  logic        we_s, re_s, is_rom_s, is_ram_s;
  logic [2:0]  rgn_s;
  logic [7:0]  din_s;
  logic [8:0]  rom_bank_q, rom_bank_eff_s, bank_sel_s;
  logic [1:0]  hi2_q;
  logic        mode_q, ram_en_q;
  logic [3:0]  ram_bank_q, ram_bank_eff_s;
  logic [22:0] byte_addr_s;
  logic [23:0] word_addr_s;

  cart_state_e state_q, state_d;
  logic        start_s, flash_start_s, complete_s;
  logic        served_q, served_d, rel_q, ready_q;
  logic [15:0] rd_addr_q;
  logic [7:0]  dout_q, rdr_data_s;
  logic        rdr_done_s;

  assign we_s     = ~I_CARTRIDGE_WE_L;
  assign re_s     = ~I_CARTRIDGE_RE_L;
  assign din_s    = IO_CARTRIDGE_DATA;
  assign rgn_s    = I_CARTRIDGE_ADDR[15:13];
  assign is_rom_s = is_rom_addr(I_CARTRIDGE_ADDR);
  assign is_ram_s = (rgn_s == RGN_CART_RAM);

  // Bank/control registers written by the CPU through the ROM window.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      rom_bank_q <= 9'd1;
      hi2_q      <= 2'd0;
      mode_q     <= 1'b0;
      ram_bank_q <= 4'd0;
      ram_en_q   <= 1'b0;
    end else if (we_s && BANKED) begin
      case (rgn_s)
        RGN_RAM_EN:   ram_en_q <= (din_s[3:0] == RAM_EN_KEY);
        RGN_ROM_BANK: begin
          if (IS_MBC1) begin
            // Bank 0 cannot be mapped into the switchable window on MBC1.
            rom_bank_q[4:0] <= (din_s[4:0] == 5'd0) ? 5'd1 : din_s[4:0];
          end else if (IS_MBC5) begin
            if (!I_CARTRIDGE_ADDR[12]) rom_bank_q[7:0] <= din_s;
            else                       rom_bank_q[8]   <= din_s[0];
          end
        end
        RGN_HI_BANK: begin
          if (IS_MBC1)      hi2_q      <= din_s[1:0];
          else if (IS_MBC5) ram_bank_q <= din_s[3:0];
        end
        RGN_MODE:     if (IS_MBC1) mode_q <= din_s[0];
        default:      ;
      endcase
    end
  end

  // Address translation: CPU address to flash word address and RAM address.
  always_comb begin
    rom_bank_eff_s = IS_MBC1 ? {2'b00, hi2_q, rom_bank_q[4:0]} :
                     IS_MBC5 ? rom_bank_q : 9'd1;
    if (I_CARTRIDGE_ADDR[14]) begin
      bank_sel_s = rom_bank_eff_s & ROM_MASK;
    end else if (IS_MBC1 && mode_q) begin
      bank_sel_s = {2'b00, hi2_q, 5'b00000} & ROM_MASK;
    end else begin
      bank_sel_s = 9'd0;
    end
    byte_addr_s = {bank_sel_s, I_CARTRIDGE_ADDR[13:0]};
    word_addr_s = FLASH_BASE + {2'b00, byte_addr_s[22:1]};
    if (IS_MBC1) begin
      ram_bank_eff_s = mode_q ? {2'b00, hi2_q} : 4'd0;
    end else if (IS_MBC5) begin
      ram_bank_eff_s = ram_bank_q & RAM_MASK;
    end else begin
      ram_bank_eff_s = 4'd0;
    end
  end

  assign O_RAM_ADDR = {ram_bank_eff_s[RAM_BANK_BITS-1:0], I_CARTRIDGE_ADDR[12:0]};
  assign O_RAM_WE   = we_s & is_ram_s & ram_en_q;
  assign O_RAM_DIN  = din_s;

  flash_async_reader #(
    .FLASH_WAIT (FLASH_WAIT),
    .FLASH_BASE (FLASH_BASE)
  ) u_reader (
    .clk_i       (I_CLK),
    .rst_ni      (I_RESET_L),
    .start_i     (flash_start_s),
    .word_addr_i (word_addr_s),
    .byte_sel_i  (byte_addr_s[0]),
    .flash_d_i   (flash_d),
    .flash_a_o   (flash_a),
    .data_o      (rdr_data_s),
    .done_o      (rdr_done_s)
  );

  // FSM state register.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state: ROM reads wait on the flash reader, RAM reads take one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  begin
        if (start_s) state_d = is_rom_s ? ST_FLASH : ST_RAM;
        else         state_d = ST_IDLE;
      end
      ST_FLASH: begin
        if (rdr_done_s) state_d = ST_IDLE;
        else            state_d = ST_FLASH;
      end
      ST_RAM:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: a read starts only when idle, not already answered, and
  // not masked by a simultaneous write.
  always_comb begin
    start_s       = 1'b0;
    flash_start_s = 1'b0;
    complete_s    = 1'b0;
    if (state_q == ST_IDLE) begin
      start_s       = re_s & ~we_s & ~served_q & (is_rom_s | is_ram_s);
      flash_start_s = start_s & is_rom_s;
    end else begin
      complete_s = (state_q == ST_RAM) | rdr_done_s;
    end
  end

  // A held read counts as answered only if strobe and address never moved
  // since it was issued; otherwise it is re-issued once back in IDLE.
  always_comb begin
    if (!re_s) begin
      served_d = 1'b0;
    end else if (complete_s) begin
      served_d = (I_CARTRIDGE_ADDR == rd_addr_q) & ~rel_q;
    end else if ((state_q == ST_IDLE) && (I_CARTRIDGE_ADDR != rd_addr_q)) begin
      served_d = 1'b0;
    end else begin
      served_d = served_q;
    end
  end

  // Read bookkeeping: issued address, strobe-release flag, answered flag, READY.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      rd_addr_q <= 16'h0000;
      rel_q     <= 1'b0;
      served_q  <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      if (start_s) rd_addr_q <= I_CARTRIDGE_ADDR;
      if (start_s)                             rel_q <= 1'b0;
      else if ((state_q != ST_IDLE) && !re_s)  rel_q <= 1'b1;
      served_q <= served_d;
      ready_q  <= (state_d == ST_IDLE);
    end
  end

  // Read data register; a new read start clears any stale byte.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      dout_q <= 8'hFF;
    end else if ((state_q == ST_FLASH) && rdr_done_s) begin
      dout_q <= rdr_data_s;
    end else if (state_q == ST_RAM) begin
      dout_q <= ram_en_q ? I_RAM_DOUT : 8'hFF;
    end else if ((state_q == ST_IDLE) && re_s && !we_s && (start_s || !(is_rom_s || is_ram_s))) begin
      dout_q <= 8'hFF;
    end
  end

  // The bus is released while a write shares the cycle with a read strobe.
  assign IO_CARTRIDGE_DATA = (re_s && !we_s) ? dout_q : 8'hzz;
  assign O_CARTRIDGE_READY = ready_q;

  assign flash_clk   = 1'b1;
  assign flash_adv_n = 1'b0;
  assign flash_ce_n  = 1'b0;
  assign flash_oe_n  = 1'b0;
  assign flash_we_n  = 1'b1;

endmodule

// File: tb/tb_cartridge_mbc.sv
// Bench for cartridge_mbc: an MBC1 and an MBC5 instance share the CPU
// strobes/address; reads push expectations, monitors compare on READY rise.
module tb_cartridge_mbc;

  typedef struct {
    logic [7:0]  data;
    logic [23:0] fa;
    bit          chk_fa;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        we_l, re_l, drv_en;
  logic [7:0]  drv_data;
  wire  [7:0]  bus1, bus5;

  logic        rdy1, rdy5;
  logic [23:0] fa1, fa5;
  logic [15:0] fd1, fd5;
  logic        fclk1, fadv1, fce1, foe1, fwe1;
  logic        fclk5, fadv5, fce5, foe5, fwe5;
  logic [16:0] raddr1, raddr5;
  logic        rwe1, rwe5;
  logic [7:0]  rdin1, rdin5, rdout1, rdout5;
  logic [7:0]  mem1 [0:131071];
  logic [7:0]  mem5 [0:131071];

  exp_t q1[$];
  exp_t q5[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   lowcnt [2];
  logic prev_rdy [2];

  always #5 clk = ~clk;

  assign bus1 = drv_en ? drv_data : 8'hzz;
  assign bus5 = drv_en ? drv_data : 8'hzz;

  // Flash image: every word is a fixed function of its address.
  function automatic logic [15:0] fword(input logic [23:0] a);
    return {a[7:0] ^ a[23:16] ^ 8'h96, a[15:8] ^ 8'h3C};
  endfunction

  function automatic exp_t ef(input logic [23:0] fa, input bit upper);
    exp_t e;
    logic [15:0] w;
    w = fword(fa);
    e.data = upper ? w[15:8] : w[7:0];
    e.fa = fa;
    e.chk_fa = 1'b1;
    e.lat = 8;
    return e;
  endfunction

  function automatic exp_t er(input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.fa = 24'h0;
    e.chk_fa = 1'b0;
    e.lat = 1;
    return e;
  endfunction

  assign fd1 = fword(fa1);
  assign fd5 = fword(fa5);

  always @(posedge clk) begin
    if (rwe1) mem1[raddr1] <= rdin1;
    rdout1 <= mem1[raddr1];
    if (rwe5) mem5[raddr5] <= rdin5;
    rdout5 <= mem5[raddr5];
  end

  cartridge_mbc #(.MBC_MODE(1), .ROM_BANK_BITS(9), .RAM_BANK_BITS(4),
                  .FLASH_WAIT(7), .FLASH_BASE(24'h000000)) u_mbc1 (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_CARTRIDGE_ADDR(addr),
    .IO_CARTRIDGE_DATA(bus1), .I_CARTRIDGE_WE_L(we_l), .I_CARTRIDGE_RE_L(re_l),
    .O_CARTRIDGE_READY(rdy1), .flash_d(fd1), .flash_a(fa1),
    .flash_clk(fclk1), .flash_adv_n(fadv1), .flash_ce_n(fce1),
    .flash_oe_n(foe1), .flash_we_n(fwe1),
    .O_RAM_ADDR(raddr1), .O_RAM_WE(rwe1), .O_RAM_DIN(rdin1), .I_RAM_DOUT(rdout1));

  cartridge_mbc #(.MBC_MODE(5), .ROM_BANK_BITS(9), .RAM_BANK_BITS(4),
                  .FLASH_WAIT(7), .FLASH_BASE(24'h000100)) u_mbc5 (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_CARTRIDGE_ADDR(addr),
    .IO_CARTRIDGE_DATA(bus5), .I_CARTRIDGE_WE_L(we_l), .I_CARTRIDGE_RE_L(re_l),
    .O_CARTRIDGE_READY(rdy5), .flash_d(fd5), .flash_a(fa5),
    .flash_clk(fclk5), .flash_adv_n(fadv5), .flash_ce_n(fce5),
    .flash_oe_n(foe5), .flash_we_n(fwe5),
    .O_RAM_ADDR(raddr5), .O_RAM_WE(rwe5), .O_RAM_DIN(rdin5), .I_RAM_DOUT(rdout5));

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic rdy, input logic [7:0] bus, input logic [23:0] fa);
    exp_t e;
    if (!rst_n) begin
      lowcnt[i] = 0;
      prev_rdy[i] = 1'b1;
    end else begin
      if (!rdy) begin
        lowcnt[i]++;
      end else if (!prev_rdy[i]) begin
        if ((i == 0 && q1.size() == 0) || (i == 1 && q5.size() == 0)) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_completion inst%0d: got data %0h expected no read", i, bus);
        end else begin
          if (i == 0) e = q1.pop_front();
          else        e = q5.pop_front();
          chk("read_data", i, {24'h0, bus}, {24'h0, e.data});
          chk("ready_low_cycles", i, lowcnt[i], e.lat);
          if (e.chk_fa) chk("flash_a", i, {8'h0, fa}, {8'h0, e.fa});
        end
        lowcnt[i] = 0;
      end
      prev_rdy[i] = rdy;
    end
  endtask

  // Monitors sample away from the rising edge.
  always @(negedge clk) begin
    mon(0, rdy1, bus1, fa1);
    mon(1, rdy5, bus5, fa5);
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; drv_data = d; drv_en = 1'b1; we_l = 1'b0;
    @(posedge clk); #1;
    we_l = 1'b1; drv_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input exp_t e1, input exp_t e5);
    int n;
    @(posedge clk); #1;
    addr = a; re_l = 1'b0;
    q1.push_back(e1);
    q5.push_back(e5);
    @(posedge clk); #1;
    n = 0;
    while (!(rdy1 && rdy5) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("read_timeout", 0, {31'd0, rdy1 & rdy5}, 32'd1);
    @(posedge clk); #1;
    re_l = 1'b1;
  endtask

  task automatic rd_unmapped(input logic [15:0] a);
    @(posedge clk); #1;
    addr = a; re_l = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("unmapped_data", 0, {24'h0, bus1}, 32'hFF);
    chk("unmapped_ready", 0, {31'd0, rdy1}, 32'd1);
    chk("unmapped_data", 1, {24'h0, bus5}, 32'hFF);
    chk("unmapped_ready", 1, {31'd0, rdy5}, 32'd1);
    @(posedge clk); #1;
    re_l = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; addr = 16'h0000; we_l = 1'b1; re_l = 1'b1;
    drv_en = 1'b0; drv_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 0, {31'd0, rdy1}, 32'd1);
    chk("reset_ready", 1, {31'd0, rdy5}, 32'd1);
    chk("reset_flash_a", 0, {8'h0, fa1}, 32'h000000);
    chk("reset_flash_a", 1, {8'h0, fa5}, 32'h000100);
    rst_n = 1'b1;

    // Power-on bank 1 in the switchable window.
    rd(16'h4000, ef(24'h002000, 1'b0), ef(24'h002100, 1'b0));
    // 00 -> MBC1 keeps bank 1, MBC5 selects bank 0.
    wr(16'h2000, 8'h00);
    rd(16'h4000, ef(24'h002000, 1'b0), ef(24'h000100, 1'b0));
    // 3000 is low-bank on MBC1, bank bit 8 on MBC5 (-> 0x100).
    wr(16'h3000, 8'h01);
    rd(16'h4001, ef(24'h002000, 1'b1), ef(24'h200100, 1'b1));

    // Cart RAM: locked, then unlocked and written.
    rd(16'hA000, er(8'hFF), er(8'hFF));
    wr(16'h0000, 8'h0A);
    wr(16'hA123, 8'h5A);
    rd(16'hA123, er(8'h5A), er(8'h5A));
    // MBC5 RAM bank 3 vs MBC1 mode 0 (bank 0).
    wr(16'h4000, 8'h03);
    wr(16'hA123, 8'hA5);
    wr(16'h4000, 8'h00);
    rd(16'hA123, er(8'hA5), er(8'h5A));

    // MBC1 mode 1: hi2 maps onto the fixed window too.
    wr(16'h4000, 8'h03);
    wr(16'h6000, 8'h01);
    rd(16'h0000, ef(24'h0C0000, 1'b0), ef(24'h000100, 1'b0));
    rd(16'h4000, ef(24'h0C2000, 1'b0), ef(24'h200100, 1'b0));

    rd_unmapped(16'h8000);
    rd_unmapped(16'hC000);

    // Bank write during an in-flight read affects only the next read.
    wr(16'h4000, 8'h00);
    wr(16'h6000, 8'h00);
    fork
      rd(16'h4000, ef(24'h002000, 1'b0), ef(24'h200100, 1'b0));
      begin
        repeat (3) @(posedge clk);
        wr(16'h2000, 8'h07);
        addr = 16'h4000;
      end
    join
    rd(16'h4000, ef(24'h00E000, 1'b0), ef(24'h20E100, 1'b0));

    // Reset three wait cycles into a flash read.
    @(posedge clk); #1;
    addr = 16'h4000; re_l = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midread_reset_ready", 0, {31'd0, rdy1}, 32'd1);
    chk("midread_reset_ready", 1, {31'd0, rdy5}, 32'd1);
    chk("midread_reset_dout", 0, {24'h0, bus1}, 32'hFF);
    chk("midread_reset_dout", 1, {24'h0, bus5}, 32'hFF);
    re_l = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(16'h4000, ef(24'h002000, 1'b0), ef(24'h002100, 1'b0));
    rd(16'hA123, er(8'hFF), er(8'hFF));

    // Low five bits zero on MBC1 still select bank 1; MBC5 takes 0x20.
    wr(16'h2000, 8'h20);
    rd(16'h4000, ef(24'h002000, 1'b0), ef(24'h040100, 1'b0));

    repeat (3) @(posedge clk);
    chk("queue_drain", 0, q1.size() + q5.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
